// File: rtl/rom_copy_engine_pkg.sv
// ============================================================================
// Module  : rom_copy_pkg
// Purpose : Shared types and constants for the ROM-to-RAM copy engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_POLL   = 3'd3,
    ST_FETCH  = 3'd4,
    ST_MEMWR  = 3'd5
  } state_t;

  // CPU register window
  localparam logic [3:0] REG_SRC    = 4'd0;
  localparam logic [3:0] REG_DST    = 4'd1;
  localparam logic [3:0] REG_LEN    = 4'd2;
  localparam logic [3:0] REG_CTRL   = 4'd3;
  localparam logic [3:0] REG_STATUS = 4'd4;
  localparam logic [3:0] REG_REMAIN = 4'd5;
  localparam logic [3:0] REG_CSUM   = 4'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERROR   = 2;
  localparam int STAT_ABORTED = 3;

  // ROM controller register window
  localparam logic [3:0] ROM_OFS_ADDR   = 4'd0;
  localparam logic [3:0] ROM_OFS_DATA   = 4'd1;
  localparam logic [3:0] ROM_OFS_STATUS = 4'd2;

  function automatic logic [15:0] status_word(input logic busy, input logic done,
                                              input logic error, input logic aborted);
    logic [15:0] w;
    w               = 16'h0000;
    w[STAT_BUSY]    = busy;
    w[STAT_DONE]    = done;
    w[STAT_ERROR]   = error;
    w[STAT_ABORTED] = aborted;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_copy_engine_if.sv
// ============================================================================
// Module  : rom_copy_engine_if
// Purpose : CPU register port, ROM-controller bus and RAM write port bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_copy_engine_if;
  logic        device_select;
  logic [3:0]  register_offset;
  logic        read_req;
  logic        write_req;
  logic [15:0] wdata;
  logic [15:0] rdata;

  logic        rom_sel;
  logic [3:0]  rom_offset;
  logic        rom_rd;
  logic        rom_wr;
  logic [15:0] rom_wdata;
  logic [15:0] rom_rdata;
  logic        rom_bus_owned;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;

  modport slave (
    input  device_select, register_offset, read_req, write_req, wdata, rom_rdata, mem_ready,
    output rdata, rom_sel, rom_offset, rom_rd, rom_wr, rom_wdata, rom_bus_owned,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output device_select, register_offset, read_req, write_req, wdata, rom_rdata, mem_ready,
    input  rdata, rom_sel, rom_offset, rom_rd, rom_wr, rom_wdata, rom_bus_owned,
           mem_addr, mem_wdata, mem_we
  );
endinterface

`default_nettype wire

// File: rtl/rom_copy_engine_regs.sv
// ============================================================================
// Module  : rom_copy_regs
// Purpose : CPU register decode, SRC/DST/LEN storage and read-data mux.
//           ROM_COPY_CHECKSUM_EN adds the checksum read port at offset 6.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_copy_regs
  import rom_copy_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        device_select,
  input  logic [3:0]  register_offset,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [15:0] wdata,
  input  logic        busy,
  input  logic        done,
  input  logic        error,
  input  logic        aborted,
  input  logic [15:0] remain,
`ifdef ROM_COPY_CHECKSUM_EN
  input  logic [15:0] csum,
`endif
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic [15:0] len,
  output logic        start,
  output logic        abort,
  output logic [15:0] rdata
);

  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        wr_en;
  logic        ctrl_wr;
  logic [15:0] rd_mux;

  assign wr_en   = device_select && write_req;
  assign ctrl_wr = wr_en && (register_offset == REG_CTRL);
  // Abort takes precedence when both bits arrive in the same write.
  assign abort   = ctrl_wr && wdata[CTRL_ABORT];
  assign start   = ctrl_wr && wdata[CTRL_START] && !wdata[CTRL_ABORT];

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    if (wr_en && !busy) begin
      case (register_offset)
        REG_SRC: src_d = wdata;
        REG_DST: dst_d = wdata;
        REG_LEN: len_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= 16'h0000;
      dst_q <= 16'h0000;
      len_q <= 16'h0000;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
    end
  end

  always_comb begin
    rd_mux = 16'hFFFF;
    case (register_offset)
      REG_SRC:    rd_mux = src_q;
      REG_DST:    rd_mux = dst_q;
      REG_LEN:    rd_mux = len_q;
      REG_STATUS: rd_mux = status_word(busy, done, error, aborted);
      REG_REMAIN: rd_mux = remain;
`ifdef ROM_COPY_CHECKSUM_EN
      REG_CSUM:   rd_mux = csum;
`endif
      default:    ;
    endcase
    rdata = (device_select && read_req) ? rd_mux : 16'h0000;
  end

  assign src = src_q;
  assign dst = dst_q;
  assign len = len_q;

endmodule

`default_nettype wire

// File: rtl/rom_copy_engine.sv
// ============================================================================
// Module  : rom_copy_engine
// Purpose : Copies words from the QSPI ROM controller into main RAM.
//           Optional: ROM_COPY_CHECKSUM_EN enables a 16-bit additive checksum.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_copy_engine
  import rom_copy_pkg::*;
#(
  parameter int POLL_SETTLE  = 4,
  parameter int POLL_TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset_n,
  rom_copy_engine_if.slave bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(POLL_SETTLE);
  localparam logic [7:0] POLL_LAST   = 8'(POLL_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        aborted_q, aborted_d;
  logic [15:0] cur_src_q, cur_src_d;
  logic [15:0] cur_dst_q, cur_dst_d;
  logic [15:0] remain_q, remain_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  polls_q, polls_d;
  logic        rom_sel_q, rom_sel_d;
  logic        rom_rd_q, rom_rd_d;
  logic        rom_wr_q, rom_wr_d;
  logic [3:0]  rom_offset_q, rom_offset_d;
  logic [15:0] rom_wdata_q, rom_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic [15:0] src, dst, len;
  logic        start, abort;
  logic        start_ok;

`ifdef ROM_COPY_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  rom_copy_regs u_regs (
    .clk             (clk),
    .reset_n         (reset_n),
    .device_select   (bus.device_select),
    .register_offset (bus.register_offset),
    .read_req        (bus.read_req),
    .write_req       (bus.write_req),
    .wdata           (bus.wdata),
    .busy            (busy_q),
    .done            (done_q),
    .error           (error_q),
    .aborted         (aborted_q),
    .remain          (remain_q),
`ifdef ROM_COPY_CHECKSUM_EN
    .csum            (csum_q),
`endif
    .src             (src),
    .dst             (dst),
    .len             (len),
    .start           (start),
    .abort           (abort),
    .rdata           (bus.rdata)
  );

  assign start_ok = start && !busy_q;

  // ROM/RAM outputs are registered: each branch sets the values the next state drives.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    aborted_d    = aborted_q;
    cur_src_d    = cur_src_q;
    cur_dst_d    = cur_dst_q;
    remain_d     = remain_q;
    settle_d     = settle_q;
    polls_d      = polls_q;
    rom_sel_d    = 1'b0;
    rom_rd_d     = 1'b0;
    rom_wr_d     = 1'b0;
    rom_offset_d = 4'd0;
    rom_wdata_d  = 16'h0000;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          aborted_d = 1'b0;
          if (len == 16'h0000) begin
            done_d = 1'b1;
          end else begin
            cur_src_d    = src;
            cur_dst_d    = dst;
            remain_d     = len;
            busy_d       = 1'b1;
            state_d      = ST_ISSUE;
            rom_sel_d    = 1'b1;
            rom_wr_d     = 1'b1;
            rom_offset_d = ROM_OFS_ADDR;
            rom_wdata_d  = src;
          end
        end
      end

      ST_ISSUE: begin
        state_d  = ST_SETTLE;
        settle_d = SETTLE_LOAD;
        polls_d  = 8'd0;
      end

      // Hold off polling so a valid bit left over from the previous word is not seen.
      ST_SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) begin
          state_d      = ST_POLL;
          rom_sel_d    = 1'b1;
          rom_rd_d     = 1'b1;
          rom_offset_d = ROM_OFS_STATUS;
        end
      end

      ST_POLL: begin
        if (bus.rom_rdata[0]) begin
          state_d      = ST_FETCH;
          rom_sel_d    = 1'b1;
          rom_rd_d     = 1'b1;
          rom_offset_d = ROM_OFS_DATA;
        end else if (polls_q == POLL_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          polls_d      = polls_q + 8'd1;
          rom_sel_d    = 1'b1;
          rom_rd_d     = 1'b1;
          rom_offset_d = ROM_OFS_STATUS;
        end
      end

      ST_FETCH: begin
        state_d     = ST_MEMWR;
        mem_we_d    = 1'b1;
        mem_addr_d  = cur_dst_q;
        mem_wdata_d = bus.rom_rdata;
      end

      ST_MEMWR: begin
        if (bus.mem_ready) begin
          mem_we_d  = 1'b0;
          cur_src_d = cur_src_q + 16'd1;
          cur_dst_d = cur_dst_q + 16'd1;
          remain_d  = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            rom_sel_d    = 1'b1;
            rom_wr_d     = 1'b1;
            rom_offset_d = ROM_OFS_ADDR;
            rom_wdata_d  = cur_src_q + 16'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort && busy_q) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      aborted_d    = 1'b1;
      mem_we_d     = 1'b0;
      rom_sel_d    = 1'b0;
      rom_rd_d     = 1'b0;
      rom_wr_d     = 1'b0;
      rom_offset_d = 4'd0;
      rom_wdata_d  = 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      aborted_q    <= 1'b0;
      cur_src_q    <= 16'h0000;
      cur_dst_q    <= 16'h0000;
      remain_q     <= 16'h0000;
      settle_q     <= 4'd0;
      polls_q      <= 8'd0;
      rom_sel_q    <= 1'b0;
      rom_rd_q     <= 1'b0;
      rom_wr_q     <= 1'b0;
      rom_offset_q <= 4'd0;
      rom_wdata_q  <= 16'h0000;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      aborted_q    <= aborted_d;
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      remain_q     <= remain_d;
      settle_q     <= settle_d;
      polls_q      <= polls_d;
      rom_sel_q    <= rom_sel_d;
      rom_rd_q     <= rom_rd_d;
      rom_wr_q     <= rom_wr_d;
      rom_offset_q <= rom_offset_d;
      rom_wdata_q  <= rom_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

`ifdef ROM_COPY_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && start_ok) begin
      csum_d = 16'h0000;
    end else if (state_q == ST_FETCH) begin
      csum_d = csum_q + bus.rom_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 16'h0000;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.rom_sel       = rom_sel_q;
  assign bus.rom_rd        = rom_rd_q;
  assign bus.rom_wr        = rom_wr_q;
  assign bus.rom_offset    = rom_offset_q;
  assign bus.rom_wdata     = rom_wdata_q;
  assign bus.rom_bus_owned = busy_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_copy_engine.sv
// ============================================================================
// Module  : tb_rom_copy_engine
// Purpose : Self-checking bench for rom_copy_engine with ROM-controller and RAM models.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rom_copy_engine;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 255;

  localparam logic [3:0] O_SRC = 4'd0, O_DST = 4'd1, O_LEN = 4'd2, O_CTRL = 4'd3;
  localparam logic [3:0] O_STAT = 4'd4, O_REM = 4'd5, O_CSUM = 4'd6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rom_copy_engine_if bus();

  rom_copy_engine #(.POLL_SETTLE(SETTLE), .POLL_TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ROM controller model: address write restarts a "valid after N cycles" countdown
  logic [15:0] rom_mem [0:65535];
  logic [15:0] rom_addr_m = 16'h0000;
  int          rom_cnt    = 0;
  int          valid_delay = 0;
  bit          never_valid = 1'b0;
  int          rom_wr_cnt = 0;
  int          poll_cnt   = 0;
  int          busy_cnt   = 0;
  int          ready_mode = 0;

  typedef struct packed {logic [15:0] a; logic [15:0] d;} wr_t;
  wr_t wq[$];

  assign bus.rom_rdata = (bus.rom_offset == 4'd2) ?
                         {15'd0, (rom_cnt == 0) && !never_valid} : rom_mem[rom_addr_m];

  always @(posedge clk) begin
    if (bus.rom_sel === 1'b1 && bus.rom_wr === 1'b1 && bus.rom_offset == 4'd0) begin
      rom_addr_m <= bus.rom_wdata;
      rom_cnt    <= valid_delay;
      rom_wr_cnt <= rom_wr_cnt + 1;
    end else if (rom_cnt > 0) begin
      rom_cnt <= rom_cnt - 1;
    end
    if (bus.rom_sel === 1'b1 && bus.rom_rd === 1'b1 && bus.rom_offset == 4'd2)
      poll_cnt <= poll_cnt + 1;
    if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1)
      wq.push_back('{bus.mem_addr, bus.mem_wdata});
    if (bus.rom_bus_owned === 1'b1)
      busy_cnt <= busy_cnt + 1;
  end

  always @(negedge clk) begin
    case (ready_mode)
      0:       bus.mem_ready = 1'b1;
      1:       bus.mem_ready = 1'($urandom_range(0, 1));
      default: bus.mem_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [3:0] ofs, input logic [15:0] d);
    @(negedge clk);
    bus.device_select   = 1'b1;
    bus.write_req       = 1'b1;
    bus.register_offset = ofs;
    bus.wdata           = d;
    @(negedge clk);
    bus.device_select = 1'b0;
    bus.write_req     = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] ofs, output logic [15:0] d);
    bus.device_select   = 1'b1;
    bus.read_req        = 1'b1;
    bus.register_offset = ofs;
    #1;
    d = bus.rdata;
    bus.device_select = 1'b0;
    bus.read_req      = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    while (bus.rom_bus_owned !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (i >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: busy=%b after %0d cycles", name, bus.rom_bus_owned, i);
    end
  endtask

  // Expected RAM image is simply ROM[src+i] at dst+i, both wrapping at 16 bits.
  task automatic run_transfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                              input int delay, input int rmode, input logic [15:0] exp_status,
                              input logic [15:0] exp_remain, input string name);
    int          base, wr0;
    logic [15:0] ea, sa, rv;
    base        = wq.size();
    wr0         = rom_wr_cnt;
    valid_delay = delay;
    ready_mode  = rmode;
    cpu_write(O_SRC, src);
    cpu_write(O_DST, dst);
    cpu_write(O_LEN, len);
    cpu_write(O_CTRL, 16'h0001);
    wait_idle(int'(len) * (delay + SETTLE + 60) + 50, name);
    check({name, " write count"}, wq.size() - base, int'(len));
    for (int i = 0; i < int'(len) && base + i < wq.size(); i++) begin
      ea = dst + 16'(i);
      sa = src + 16'(i);
      check({name, " addr"}, wq[base + i].a, ea);
      check({name, " data"}, wq[base + i].d, rom_mem[sa]);
    end
    check({name, " rom addr writes"}, rom_wr_cnt - wr0, int'(len));
    cpu_read(O_STAT, rv);
    check({name, " status"}, rv, exp_status);
    cpu_read(O_REM, rv);
    check({name, " remain"}, rv, exp_remain);
    check({name, " idle outputs"}, {bus.rom_sel, bus.rom_rd, bus.rom_wr, bus.mem_we}, 4'b0000);
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int          delay;
    int          rmode;
    logic [15:0] exp_status;
    logic [15:0] exp_remain;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [15:0] rv, a0, d0, exp_csum, rsrc, rdst, rlen;
    logic [15:0] reset_exp[8];
    int          base, w0, p0, b0, i;
    bit          stable;

    vecs[0] = '{16'h0010, 16'h8000, 16'd3, 10, 0, 16'h0002, 16'h0000};
    vecs[1] = '{16'h1234, 16'h0100, 16'd1,  0, 1, 16'h0002, 16'h0000};
    vecs[2] = '{16'hFFFE, 16'h2000, 16'd4,  3, 1, 16'h0002, 16'h0000};
    vecs[3] = '{16'h0040, 16'hFFFF, 16'd2,  0, 0, 16'h0002, 16'h0000};
    vecs[4] = '{16'h0300, 16'hFFFE, 16'd5,  2, 1, 16'h0002, 16'h0000};

`ifdef ROM_COPY_CHECKSUM_EN
    reset_exp = '{16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0000, 16'hFFFF};
`else
    reset_exp = '{16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF};
`endif

    for (int k = 0; k < 65536; k++) rom_mem[k] = 16'($urandom);

    bus.device_select   = 1'b0;
    bus.register_offset = 4'd0;
    bus.read_req        = 1'b0;
    bus.write_req       = 1'b0;
    bus.wdata           = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    for (int k = 0; k < 8; k++) begin
      cpu_read(4'(k), rv);
      check($sformatf("reset reg %0d", k), rv, reset_exp[k]);
    end
    check("reset rom outputs", {bus.rom_sel, bus.rom_rd, bus.rom_wr, bus.rom_offset, bus.rom_wdata}, 0);
    check("reset mem outputs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rom_bus_owned}, 0);

    // Poll timeout: valid never rises
    never_valid = 1'b1;
    ready_mode  = 0;
    p0   = poll_cnt;
    base = wq.size();
    cpu_write(O_SRC, 16'h0500);
    cpu_write(O_DST, 16'h0600);
    cpu_write(O_LEN, 16'd3);
    cpu_write(O_CTRL, 16'h0001);
    wait_idle(TIMEOUT + 60, "timeout");
    check("timeout poll count", poll_cnt - p0, TIMEOUT);
    cpu_read(O_STAT, rv);
    check("timeout status", rv, 16'h0004);
    cpu_read(O_REM, rv);
    check("timeout remain", rv, 16'd3);
    check("timeout bus owned", bus.rom_bus_owned, 1'b0);
    check("timeout no writes", wq.size() - base, 0);
    never_valid = 1'b0;

    // LEN==0 start
    b0   = busy_cnt;
    w0   = rom_wr_cnt;
    base = wq.size();
    cpu_write(O_LEN, 16'd0);
    cpu_write(O_CTRL, 16'h0001);
    cpu_read(O_STAT, rv);
    check("len0 status", rv, 16'h0002);
    repeat (3) @(negedge clk);
    check("len0 never busy", busy_cnt - b0, 0);
    check("len0 no rom write", rom_wr_cnt - w0, 0);
    check("len0 no mem write", wq.size() - base, 0);
    cpu_write(O_CTRL, 16'h0002);
    cpu_read(O_STAT, rv);
    check("idle abort ignored", rv, 16'h0002);

    // Table-driven transfers
    for (int k = 0; k < 5; k++)
      run_transfer(vecs[k].src, vecs[k].dst, vecs[k].len, vecs[k].delay, vecs[k].rmode,
                   vecs[k].exp_status, vecs[k].exp_remain, $sformatf("vec%0d", k));

    // Randomized transfers
    for (int k = 0; k < 4; k++) begin
      rsrc = 16'($urandom);
      rdst = 16'($urandom);
      rlen = 16'($urandom_range(1, 6));
      run_transfer(rsrc, rdst, rlen, int'($urandom_range(0, 12)), 1, 16'h0002, 16'h0000,
                   $sformatf("rand%0d", k));
    end

    // RAM back-pressure: write must hold steady and happen once
    ready_mode  = 2;
    valid_delay = 0;
    base        = wq.size();
    cpu_write(O_SRC, 16'h0700);
    cpu_write(O_DST, 16'h0900);
    cpu_write(O_LEN, 16'd2);
    cpu_write(O_CTRL, 16'h0001);
    i = 0;
    while (bus.mem_we !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("stall we raised", bus.mem_we, 1'b1);
    a0 = bus.mem_addr;
    d0 = bus.mem_wdata;
    check("stall addr", a0, 16'h0900);
    check("stall data", d0, rom_mem[16'h0700]);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== a0 || bus.mem_wdata !== d0) stable = 1'b0;
    end
    check("stall stable", stable, 1'b1);
    cpu_read(O_REM, rv);
    check("stall remain held", rv, 16'd2);
    cpu_write(O_SRC, 16'hAAAA);
    cpu_write(O_CTRL, 16'h0001);
    check("stall no write yet", wq.size() - base, 0);
    ready_mode = 0;
    wait_idle(200, "stall");
    check("stall write count", wq.size() - base, 2);
    check("stall write0", wq[base], {16'h0900, rom_mem[16'h0700]});
    check("stall write1", wq[base + 1], {16'h0901, rom_mem[16'h0701]});
    cpu_read(O_SRC, rv);
    check("src write while busy ignored", rv, 16'h0700);
    cpu_read(O_REM, rv);
    check("stall remain end", rv, 16'd0);

    // Destination wrap then abort while polling word 2
    valid_delay = 20;
    ready_mode  = 0;
    base        = wq.size();
    cpu_write(O_SRC, 16'h0020);
    cpu_write(O_DST, 16'hFFFF);
    cpu_write(O_LEN, 16'd2);
    cpu_write(O_CTRL, 16'h0001);
    i = 0;
    while (wq.size() - base < 1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    i = 0;
    while (!(bus.rom_sel === 1'b1 && bus.rom_rd === 1'b1 && bus.rom_offset == 4'd2) && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("abort reached poll", {bus.rom_sel, bus.rom_rd, bus.rom_offset}, {2'b11, 4'd2});
    cpu_write(O_CTRL, 16'h0003);
    cpu_read(O_STAT, rv);
    check("abort status", rv, 16'h0008);
    cpu_read(O_REM, rv);
    check("abort remain", rv, 16'd1);
    check("abort bus owned", bus.rom_bus_owned, 1'b0);
    check("abort write count", wq.size() - base, 1);
    check("abort first write", wq[base], {16'hFFFF, rom_mem[16'h0020]});
    w0 = rom_wr_cnt;
    p0 = poll_cnt;
    repeat (10) @(negedge clk);
    check("abort rom quiet", {rom_wr_cnt - w0, poll_cnt - p0}, 0);

    // Checksum (wraps mod 2^16)
    rom_mem[16'h0100] = 16'h8000;
    rom_mem[16'h0101] = 16'h8001;
    run_transfer(16'h0100, 16'h0A00, 16'd2, 0, 0, 16'h0002, 16'h0000, "csum xfer");
`ifdef ROM_COPY_CHECKSUM_EN
    exp_csum = rom_mem[16'h0100] + rom_mem[16'h0101];
`else
    exp_csum = 16'hFFFF;
`endif
    cpu_read(O_CSUM, rv);
    check("checksum", rv, exp_csum);

    // Asynchronous reset mid-transfer
    valid_delay = 5;
    cpu_write(O_SRC, 16'h0055);
    cpu_write(O_LEN, 16'd4);
    cpu_write(O_CTRL, 16'h0001);
    repeat (8) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset outputs",
          {bus.rom_bus_owned, bus.rom_sel, bus.rom_rd, bus.rom_wr, bus.mem_we, bus.mem_addr}, 0);
    cpu_read(O_SRC, rv);
    check("async reset src", rv, 16'h0000);
    cpu_read(O_REM, rv);
    check("async reset remain", rv, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
